// File: rtl/watch_pkg.sv
// Shared widths and field limits for the watch timekeeping datapath.
package watch_pkg;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;
   localparam int MSEC_W = 7;

   localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
   localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

endpackage

// File: rtl/watch_dp_if.sv
// Set/clear controls from the watch control unit and time outputs to the FND mux.
interface watch_dp_if;
   import watch_pkg::*;

   logic              i_hour_set;
   logic              i_min_set;
   logic              i_sec_set;
   logic [HOUR_W-1:0] i_hour_value;
   logic [MIN_W-1:0]  i_min_value;
   logic [SEC_W-1:0]  i_sec_value;
   logic              i_clear;
   logic              i_set_mode_active;
   logic [MSEC_W-1:0] o_msec;
   logic [SEC_W-1:0]  o_sec;
   logic [MIN_W-1:0]  o_min;
   logic [HOUR_W-1:0] o_hour;
   logic              o_tick;

   modport master (
      output i_hour_set, i_min_set, i_sec_set,
      output i_hour_value, i_min_value, i_sec_value,
      output i_clear, i_set_mode_active,
      input  o_msec, o_sec, o_min, o_hour, o_tick
   );

   modport slave (
      input  i_hour_set, i_min_set, i_sec_set,
      input  i_hour_value, i_min_value, i_sec_value,
      input  i_clear, i_set_mode_active,
      output o_msec, o_sec, o_min, o_hour, o_tick
   );

endinterface

// File: rtl/watch_tick_gen.sv
// Prescaler producing a one-cycle strobe every CLK_FREQ/TICK_HZ clocks; held at 0 by clear/hold.
module watch_tick_gen #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int TICK_HZ  = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_hold,
   output logic o_tick
);

   localparam int DIV  = CLK_FREQ / TICK_HZ;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (i_clear || i_hold)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

   // Combinational strobe; the datapath registers it so o_tick lines up with the msec update.
   assign o_tick = !i_clear && !i_hold && (cnt == LAST);

endmodule

// File: rtl/watch_dp.sv
// Timekeeping datapath: hour:min:sec:sub-second cascade with field set strobes, clear and set-mode freeze.
module watch_dp
   import watch_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int TICK_HZ  = 100
) (
   input  logic        clk,
   input  logic        rst,
   watch_dp_if.slave   bus
);

   localparam logic [MSEC_W-1:0] MSEC_MAX = MSEC_W'(TICK_HZ - 1);

   logic              tick;
   logic              msec_wrap;
   logic              sec_carry;
   logic              min_carry;
   logic [MSEC_W-1:0] msec_q;
   logic [SEC_W-1:0]  sec_q;
   logic [MIN_W-1:0]  min_q;
   logic [HOUR_W-1:0] hour_q;
   logic              tick_q;

   watch_tick_gen #(
      .CLK_FREQ (CLK_FREQ),
      .TICK_HZ  (TICK_HZ)
   ) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .i_clear (bus.i_clear),
      .i_hold  (bus.i_set_mode_active),
      .o_tick  (tick)
   );

   // A strobed field never carries onward, even if its load value was rejected.
   assign msec_wrap = tick && (msec_q == MSEC_MAX);
   assign sec_carry = msec_wrap && (sec_q == SEC_MAX) && !bus.i_sec_set;
   assign min_carry = sec_carry && (min_q == MIN_MAX) && !bus.i_min_set;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         msec_q <= '0;
      else if (bus.i_clear || bus.i_set_mode_active)
         msec_q <= '0;
      else if (tick)
         msec_q <= msec_wrap ? '0 : msec_q + MSEC_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sec_q <= '0;
      else if (bus.i_clear)
         sec_q <= '0;
      else if (bus.i_sec_set) begin
         if (bus.i_sec_value <= SEC_MAX)
            sec_q <= bus.i_sec_value;
      end
      else if (msec_wrap)
         sec_q <= (sec_q == SEC_MAX) ? '0 : sec_q + SEC_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         min_q <= '0;
      else if (bus.i_clear)
         min_q <= '0;
      else if (bus.i_min_set) begin
         if (bus.i_min_value <= MIN_MAX)
            min_q <= bus.i_min_value;
      end
      else if (sec_carry)
         min_q <= (min_q == MIN_MAX) ? '0 : min_q + MIN_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         hour_q <= '0;
      else if (bus.i_clear)
         hour_q <= '0;
      else if (bus.i_hour_set) begin
         if (bus.i_hour_value <= HOUR_MAX)
            hour_q <= bus.i_hour_value;
      end
      else if (min_carry)
         hour_q <= (hour_q == HOUR_MAX) ? '0 : hour_q + HOUR_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tick_q <= 1'b0;
      else
         tick_q <= tick;
   end

   assign bus.o_msec = msec_q;
   assign bus.o_sec  = sec_q;
   assign bus.o_min  = min_q;
   assign bus.o_hour = hour_q;
   assign bus.o_tick = tick_q;

endmodule

// File: tb/tb_watch_dp.sv
// Directed bench for watch_dp at CLK_FREQ=1000, TICK_HZ=10 (100 clocks per tick).
module tb_watch_dp;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_run  = 0;
   int   n_fail = 0;

   watch_dp_if wif ();

   watch_dp #(
      .CLK_FREQ (1000),
      .TICK_HZ  (10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (wif.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_run++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   // Returns edges until o_tick is seen; budget+1 if it never came.
   task automatic wait_tick(input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!wif.o_tick && n <= budget);
   endtask

   task automatic wait_msec(input string tag, input int target);
      int n;
      for (int i = 0; i < 12; i++) begin
         wait_tick(150, n);
         if (wif.o_msec == target) break;
      end
      chk(tag, wif.o_msec, target);
   endtask

   task automatic load(input logic hs, input int hv, input logic ms, input int mv,
                       input logic ss, input int sv);
      wif.i_hour_set   = hs;
      wif.i_hour_value = 5'(hv);
      wif.i_min_set    = ms;
      wif.i_min_value  = 6'(mv);
      wif.i_sec_set    = ss;
      wif.i_sec_value  = 6'(sv);
      step();
      wif.i_hour_set = 1'b0;
      wif.i_min_set  = 1'b0;
      wif.i_sec_set  = 1'b0;
   endtask

   task automatic chk_time(input string tag, input int h, input int m, input int s, input int ms);
      chk({tag, "_hour"}, wif.o_hour, h);
      chk({tag, "_min"},  wif.o_min,  m);
      chk({tag, "_sec"},  wif.o_sec,  s);
      chk({tag, "_msec"}, wif.o_msec, ms);
   endtask

   initial begin
      int n;
      int ticks;
      wif.i_hour_set        = 1'b0;
      wif.i_min_set         = 1'b0;
      wif.i_sec_set         = 1'b0;
      wif.i_hour_value      = '0;
      wif.i_min_value       = '0;
      wif.i_sec_value       = '0;
      wif.i_clear           = 1'b0;
      wif.i_set_mode_active = 1'b0;

      // 1: reset release and free run
      steps(3);
      chk_time("rst", 0, 0, 0, 0);
      chk("rst_tick", wif.o_tick, 0);
      rst = 1'b0;
      wait_tick(200, n);
      chk("first_tick_cycles", n, 100);
      chk("first_tick_msec", wif.o_msec, 1);
      steps(900);
      chk("one_sec_sec", wif.o_sec, 1);
      chk("one_sec_msec", wif.o_msec, 0);

      // 2: full rollover from 23:59:59.9
      load(1'b1, 23, 1'b1, 59, 1'b1, 59);
      chk_time("load_235959", 23, 59, 59, 0);
      wait_msec("roll_reach9", 9);
      wait_tick(150, n);
      chk("roll_tick_cycles", n, 100);
      chk_time("rollover", 0, 0, 0, 0);

      // 3: set-mode freeze from 00:00:03.4
      load(1'b0, 0, 1'b0, 0, 1'b1, 3);
      wait_msec("freeze_reach4", 4);
      chk("freeze_start_sec", wif.o_sec, 3);
      wif.i_set_mode_active = 1'b1;
      ticks = 0;
      for (int i = 0; i < 500; i++) begin
         step();
         if (wif.o_tick) ticks++;
      end
      chk("freeze_ticks", ticks, 0);
      chk_time("freeze", 0, 0, 3, 0);
      wif.i_set_mode_active = 1'b0;
      wait_tick(200, n);
      chk("unfreeze_cycles", n, 100);
      chk("unfreeze_msec", wif.o_msec, 1);
      chk("unfreeze_sec", wif.o_sec, 3);

      // 4: out-of-range loads are ignored
      load(1'b1, 5, 1'b1, 7, 1'b0, 0);
      chk("hour_load5", wif.o_hour, 5);
      chk("min_load7", wif.o_min, 7);
      load(1'b1, 24, 1'b0, 0, 1'b0, 0);
      chk("hour_24_ignored", wif.o_hour, 5);
      load(1'b0, 0, 1'b1, 60, 1'b0, 0);
      chk("min_60_ignored", wif.o_min, 7);
      load(1'b0, 0, 1'b0, 0, 1'b1, 59);
      chk("sec_load59", wif.o_sec, 59);

      // 5: sec load collides with the msec carry at 00:05:59.9
      load(1'b1, 0, 1'b1, 5, 1'b1, 59);
      chk_time("pre_collide", 0, 5, 59, wif.o_msec);
      wait_msec("collide_reach9", 9);
      steps(99);
      chk("collide_no_tick_yet", wif.o_tick, 0);
      load(1'b0, 0, 1'b0, 0, 1'b1, 10);
      chk("collide_tick", wif.o_tick, 1);
      chk_time("collide", 0, 5, 10, 0);

      // 6: clear beats set strobe; async reset between edges
      load(1'b0, 0, 1'b1, 9, 1'b1, 20);
      wif.i_clear = 1'b1;
      load(1'b1, 7, 1'b0, 0, 1'b0, 0);
      chk_time("clear", 0, 0, 0, 0);
      chk("clear_tick", wif.o_tick, 0);
      steps(150);
      chk("clear_hold_msec", wif.o_msec, 0);
      wif.i_clear = 1'b0;
      wait_tick(200, n);
      chk("post_clear_cycles", n, 100);
      load(1'b1, 12, 1'b1, 34, 1'b1, 56);
      chk_time("pre_rst", 12, 34, 56, 1);
      #2;
      rst = 1'b1;
      #1;
      chk_time("async_rst", 0, 0, 0, 0);
      #1;
      rst = 1'b0;
      wait_tick(200, n);
      chk("post_rst_cycles", n, 100);
      chk("post_rst_msec", wif.o_msec, 1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1);
   end

endmodule
